// File: rtl/cpu_load_run_ctrl.sv
// Program loader and run/step sequencer for cpu_core.
// Packs a byte stream into imem words, then gates the core clock enable.
module cpu_load_run_ctrl #(
   parameter int NB_INSTRUCTION  = 32,
   parameter int NB_BYTE         = 8,
   parameter int IMEM_ADDR_WIDTH = 5,
   parameter int NB_CYCLES       = 16
) (
   input  logic                       clk,
   input  logic                       i_rst,
   input  logic [NB_BYTE-1:0]         i_rx_data,
   input  logic                       i_rx_valid,
   input  logic                       i_cmd_load,
   input  logic                       i_cmd_run,
   input  logic                       i_cmd_step,
   input  logic                       i_halt,
   output logic [NB_INSTRUCTION-1:0]  o_imem_data,
   output logic [IMEM_ADDR_WIDTH-1:0] o_imem_waddr,
   output logic                       o_imem_wen,
   output logic [1:0]                 o_mem_wsize,
   output logic                       o_cpu_en,
   output logic                       o_cpu_rst,
   output logic [2:0]                 o_state,
   output logic [IMEM_ADDR_WIDTH:0]   o_words_loaded,
   output logic [NB_CYCLES-1:0]       o_cycle_count,
   output logic                       o_load_err
);

   localparam int BPW = NB_INSTRUCTION / NB_BYTE;
   localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [IMEM_ADDR_WIDTH:0] LAST_ADDR =
      {1'b0, {IMEM_ADDR_WIDTH{1'b1}}};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      READY = 3'd2,
      RUN   = 3'd3,
      STEP  = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t state, state_n;

   logic [BCW-1:0]                    byte_cnt;
   logic [NB_INSTRUCTION-1:0]         shift;
   logic [NB_INSTRUCTION+NB_BYTE-1:0] cat;
   logic [NB_INSTRUCTION-1:0]         word;
   logic                              last_byte;
   logic                              sentinel;
   logic                              mem_full;
   logic                              start_load;
   logic                              write;

   // little-endian: bytes enter at the top and drift down
   assign cat       = {i_rx_data, shift};
   assign word      = cat[NB_INSTRUCTION+NB_BYTE-1:NB_BYTE];
   assign last_byte = i_rx_valid && (byte_cnt == BCW'(BPW - 1));
   assign sentinel  = &word;
   assign mem_full  = (o_words_loaded == LAST_ADDR);

   assign o_state     = state;
   assign o_mem_wsize = 2'b10;

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n    = state;
      start_load = 1'b0;
      write      = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_cmd_load) begin
               state_n    = LOAD;
               start_load = 1'b1;
            end
         end
         LOAD: begin
            if (i_cmd_load) begin
               start_load = 1'b1;
            end else if (last_byte) begin
               write = 1'b1;
               if (sentinel || mem_full) state_n = READY;
            end
         end
         READY: begin
            if (i_cmd_load) begin
               state_n    = LOAD;
               start_load = 1'b1;
            end else if (i_cmd_run) begin
               state_n = RUN;
            end else if (i_cmd_step) begin
               state_n = STEP;
            end
         end
         RUN: begin
            if (i_halt) state_n = DONE;
         end
         STEP: begin
            state_n = i_halt ? DONE : READY;
         end
         DONE: begin
            if (i_cmd_load) begin
               state_n    = LOAD;
               start_load = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         byte_cnt       <= '0;
         shift          <= '0;
         o_imem_data    <= '0;
         o_imem_waddr   <= '0;
         o_imem_wen     <= 1'b0;
         o_cpu_en       <= 1'b0;
         o_cpu_rst      <= 1'b1;
         o_words_loaded <= '0;
         o_cycle_count  <= '0;
         o_load_err     <= 1'b0;
      end else begin
         o_imem_wen <= write;
         o_cpu_rst  <= (state_n == IDLE) || (state_n == LOAD);
         o_cpu_en   <= (state_n == RUN) || (state_n == STEP);
         if (start_load) begin
            byte_cnt       <= '0;
            o_words_loaded <= '0;
            o_load_err     <= 1'b0;
            o_cycle_count  <= '0;
         end else begin
            if (state == LOAD && i_rx_valid) begin
               shift    <= word;
               byte_cnt <= last_byte ? '0 : byte_cnt + BCW'(1);
               if (last_byte) begin
                  o_imem_data    <= word;
                  o_imem_waddr   <= o_words_loaded[IMEM_ADDR_WIDTH-1:0];
                  o_words_loaded <= o_words_loaded + 1'b1;
                  if (mem_full && !sentinel) o_load_err <= 1'b1;
               end
            end
            // saturate rather than wrap
            if ((state == RUN || state == STEP) && o_cycle_count != '1)
               o_cycle_count <= o_cycle_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cpu_load_run_ctrl.sv
// Bench for cpu_load_run_ctrl: random program loads against a word-list
// model, plus step, run/halt, priority, saturation and mid-load reset.
module tb_cpu_load_run_ctrl;

   localparam int NC = 6;

   logic            clk = 1'b0;
   logic            i_rst;
   logic [7:0]      i_rx_data;
   logic            i_rx_valid;
   logic            i_cmd_load;
   logic            i_cmd_run;
   logic            i_cmd_step;
   logic            i_halt;
   logic [31:0]     o_imem_data;
   logic [4:0]      o_imem_waddr;
   logic            o_imem_wen;
   logic [1:0]      o_mem_wsize;
   logic            o_cpu_en;
   logic            o_cpu_rst;
   logic [2:0]      o_state;
   logic [5:0]      o_words_loaded;
   logic [NC-1:0]   o_cycle_count;
   logic            o_load_err;

   always #5 clk = ~clk;

   cpu_load_run_ctrl #(
      .NB_INSTRUCTION(32),
      .NB_BYTE(8),
      .IMEM_ADDR_WIDTH(5),
      .NB_CYCLES(NC)
   ) dut (
      .clk(clk),
      .i_rst(i_rst),
      .i_rx_data(i_rx_data),
      .i_rx_valid(i_rx_valid),
      .i_cmd_load(i_cmd_load),
      .i_cmd_run(i_cmd_run),
      .i_cmd_step(i_cmd_step),
      .i_halt(i_halt),
      .o_imem_data(o_imem_data),
      .o_imem_waddr(o_imem_waddr),
      .o_imem_wen(o_imem_wen),
      .o_mem_wsize(o_mem_wsize),
      .o_cpu_en(o_cpu_en),
      .o_cpu_rst(o_cpu_rst),
      .o_state(o_state),
      .o_words_loaded(o_words_loaded),
      .o_cycle_count(o_cycle_count),
      .o_load_err(o_load_err)
   );

   int          total = 0;
   int          bad   = 0;
   int          en_cnt = 0;
   logic [36:0] wr_q[$];
   logic [31:0] exp_q[$];
   logic [7:0]  bq[$];
   bit          exp_err;
   bit          exp_done;

   always @(negedge clk) begin
      if (o_imem_wen) wr_q.push_back({o_imem_waddr, o_imem_data});
      if (o_cpu_en) en_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic [7:0] b[$]);
      logic [31:0] w;
      int k;
      exp_q.delete();
      exp_err  = 0;
      exp_done = 0;
      w = 0;
      k = 0;
      foreach (b[i]) begin
         if (exp_done) break;
         w = w | (32'(b[i]) << (8 * k));
         k++;
         if (k == 4) begin
            exp_q.push_back(w);
            if (w == 32'hFFFF_FFFF) exp_done = 1;
            else if (exp_q.size() == 32) begin
               exp_done = 1;
               exp_err  = 1;
            end
            w = 0;
            k = 0;
         end
      end
   endtask

   task automatic make_prog(input int nw, input int spos, input int extra);
      logic [31:0] w;
      bq.delete();
      for (int i = 0; i < nw; i++) begin
         w = $urandom;
         if (w == 32'hFFFF_FFFF) w = 32'h0;
         if (i == spos) w = 32'hFFFF_FFFF;
         for (int j = 0; j < 4; j++) bq.push_back(8'(w >> (8 * j)));
      end
      for (int i = 0; i < extra; i++) bq.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic run_load(input logic [7:0] b[$], input bit gaps);
      int base;
      i_cmd_load = 1'b1;
      tick();
      i_cmd_load = 1'b0;
      chk("load_entry_state", o_state, 1);
      chk("load_entry_cpu_rst", o_cpu_rst, 1);
      chk("load_entry_cycles", o_cycle_count, 0);
      chk("load_entry_words", o_words_loaded, 0);
      base = wr_q.size();
      foreach (b[i]) begin
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         i_rx_valid = 1'b1;
         i_rx_data  = b[i];
         tick();
         i_rx_valid = 1'b0;
      end
      repeat (3) tick();
      model(b);
      chk("wr_count", wr_q.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size() && base + i < wr_q.size(); i++) begin
         chk("wr_addr", wr_q[base+i][36:32], i);
         chk("wr_data", wr_q[base+i][31:0], exp_q[i]);
      end
      chk("load_state", o_state, exp_done ? 2 : 1);
      chk("words_loaded", o_words_loaded, exp_q.size());
      chk("load_err", o_load_err, exp_err);
      chk("load_cpu_rst", o_cpu_rst, exp_done ? 0 : 1);
   endtask

   task automatic step_once(input bit halt, input int exp_cnt);
      i_cmd_step = 1'b1;
      i_halt     = halt;
      tick();
      i_cmd_step = 1'b0;
      chk("step_state", o_state, 4);
      chk("step_en", o_cpu_en, 1);
      tick();
      i_halt = 1'b0;
      chk("after_step_state", o_state, halt ? 5 : 2);
      chk("after_step_en", o_cpu_en, 0);
      chk("step_cycles", o_cycle_count, exp_cnt);
   endtask

   initial begin
      int n;
      int base;
      i_rst      = 1'b1;
      i_rx_data  = '0;
      i_rx_valid = 1'b0;
      i_cmd_load = 1'b0;
      i_cmd_run  = 1'b0;
      i_cmd_step = 1'b0;
      i_halt     = 1'b0;
      repeat (3) tick();
      i_rst = 1'b0;
      tick();
      chk("rst_state", o_state, 0);
      chk("rst_cpu_rst", o_cpu_rst, 1);
      chk("rst_cpu_en", o_cpu_en, 0);
      chk("rst_wen", o_imem_wen, 0);
      chk("rst_wsize", o_mem_wsize, 2'b10);
      chk("rst_words", o_words_loaded, 0);
      chk("rst_cycles", o_cycle_count, 0);
      chk("rst_err", o_load_err, 0);
      chk("rst_data", o_imem_data, 0);

      // ignored when idle
      i_cmd_run = 1'b1;
      i_cmd_step = 1'b1;
      tick();
      i_cmd_run = 1'b0;
      i_cmd_step = 1'b0;
      chk("idle_ignore", o_state, 0);

      bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      run_load(bq, 1'b0);

      // full memory, then trailing bytes must not write
      make_prog(33, -1, 0);
      run_load(bq, 1'b0);

      for (int it = 0; it < 8; it++) begin
         n = $urandom_range(1, 36);
         make_prog(n, $urandom_range(0, n), $urandom_range(0, 3));
         run_load(bq, $urandom_range(0, 1) == 1);
      end

      make_prog(4, 3, 0);
      run_load(bq, 1'b1);
      base = en_cnt;
      for (int i = 1; i <= 3; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         step_once(1'b0, i);
      end
      chk("step_pulses", en_cnt - base, 3);
      i_rx_valid = 1'b1;
      tick();
      i_rx_valid = 1'b0;
      chk("ready_ignores_rx", o_state, 2);
      step_once(1'b1, 4);

      make_prog(2, 1, 0);
      run_load(bq, 1'b0);
      n = $urandom_range(5, 30);
      base = en_cnt;
      i_cmd_run = 1'b1;
      tick();
      i_cmd_run = 1'b0;
      repeat (n - 1) tick();
      i_halt = 1'b1;
      tick();
      i_halt = 1'b0;
      chk("halt_state", o_state, 5);
      chk("halt_en", o_cpu_en, 0);
      chk("halt_cycles", o_cycle_count, n);
      chk("run_pulses", en_cnt - base, n);
      i_cmd_run = 1'b1;
      i_cmd_step = 1'b1;
      tick();
      i_cmd_run = 1'b0;
      i_cmd_step = 1'b0;
      tick();
      chk("done_ignore_state", o_state, 5);
      chk("done_frozen", o_cycle_count, n);

      make_prog(1, 0, 0);
      run_load(bq, 1'b0);
      i_cmd_run = 1'b1;
      tick();
      i_cmd_run = 1'b0;
      repeat (80) tick();
      chk("sat_cycles", o_cycle_count, (1 << NC) - 1);
      i_cmd_load = 1'b1;
      tick();
      i_cmd_load = 1'b0;
      chk("run_ignores_load", o_state, 3);
      chk("run_en", o_cpu_en, 1);
      i_halt = 1'b1;
      tick();
      i_halt = 1'b0;
      chk("sat_halt", o_state, 5);

      make_prog(3, 2, 0);
      run_load(bq, 1'b0);
      step_once(1'b0, 1);
      i_cmd_load = 1'b1;
      i_cmd_run  = 1'b1;
      i_cmd_step = 1'b1;
      tick();
      i_cmd_load = 1'b0;
      i_cmd_run  = 1'b0;
      i_cmd_step = 1'b0;
      chk("prio_state", o_state, 1);
      chk("prio_cycles", o_cycle_count, 0);
      chk("prio_cpu_rst", o_cpu_rst, 1);
      chk("prio_en", o_cpu_en, 0);

      // reset after a partial word
      base = wr_q.size();
      for (int i = 0; i < 2; i++) begin
         i_rx_valid = 1'b1;
         i_rx_data  = 8'h5A;
         tick();
      end
      i_rx_valid = 1'b0;
      #2 i_rst = 1'b1;
      #1;
      chk("async_rst_state", o_state, 0);
      chk("async_rst_cpu_rst", o_cpu_rst, 1);
      tick();
      i_rst = 1'b0;
      tick();
      chk("rst_no_write", wr_q.size() - base, 0);
      bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      run_load(bq, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
